// File: rtl/keypad_pkg.sv
// Shared constants, types and key-map helpers for the memory-mapped keypad port.
package keypad_pkg;

    localparam int unsigned NUM_COLS  = 4;
    localparam int unsigned NUM_ROWS  = 4;
    localparam int unsigned NUM_KEYS  = NUM_COLS * NUM_ROWS;

    localparam int unsigned VALID_BIT = 31;
    localparam int unsigned OVR_BIT   = 30;
    localparam int unsigned CODE_LSB  = 0;

    typedef logic [NUM_KEYS-1:0] key_map_t;

    typedef enum logic [1:0] {StCol0, StCol1, StCol2, StCol3} col_state_e;

    function automatic logic is_onehot(key_map_t m);
        return (m != '0) && ((m & (m - key_map_t'(1))) == '0);
    endfunction

    // Bit index equals 4*row + col because snap is assembled as snap[4*r+c].
    function automatic logic [3:0] key_code(key_map_t m);
        logic [3:0] code;
        code = 4'd0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (m[i]) code = 4'(i);
        end
        return code;
    endfunction

endpackage

// File: rtl/keypad_if.sv
// CPU-side read port of the keypad: read strobe in, key register view out.
interface keypad_if;
    logic        rd_strobe;
    logic [31:0] key_reg;

    modport master (output rd_strobe, input key_reg);
    modport slave  (input rd_strobe, output key_reg);
endinterface

// File: rtl/keypad_col_scanner.sv
// Column scanner: drives one column low per slot, synchronises rows and assembles the key map.
module keypad_col_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output key_map_t   snap,
    output logic       scan_done
);

    localparam int unsigned DivW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DivW-1:0] DivLast = DivW'(SCAN_DIV - 1);

    col_state_e      state_q, state_d;
    logic [DivW-1:0] div_q, div_d;
    logic [3:0]      sync1_q, sync2_q;
    key_map_t        snap_q, snap_d;
    logic            slot_end;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StCol0;
            div_q   <= '0;
            sync1_q <= '0;
            sync2_q <= '0;
            snap_q  <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            sync1_q <= row_in;
            sync2_q <= sync1_q;
            snap_q  <= snap_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        div_d    = div_q + DivW'(1);
        snap_d   = snap_q;
        slot_end = (div_q == DivLast);
        if (slot_end) begin
            div_d = '0;
            // Rows are active-low on the pins; a pressed key reads as 1 in the map.
            for (int r = 0; r < NUM_ROWS; r++) begin
                snap_d[NUM_COLS * r + int'(state_q)] = ~sync2_q[r];
            end
            unique case (state_q)
                StCol0:  state_d = StCol1;
                StCol1:  state_d = StCol2;
                StCol2:  state_d = StCol3;
                StCol3:  state_d = StCol0;
                default: state_d = StCol0;
            endcase
        end
    end

    always_comb begin
        col_out = 4'b1110;
        unique case (state_q)
            StCol0:  col_out = 4'b1110;
            StCol1:  col_out = 4'b1101;
            StCol2:  col_out = 4'b1011;
            StCol3:  col_out = 4'b0111;
            default: col_out = 4'b1110;
        endcase
    end

    // The map handed out includes the column-3 sample being taken this cycle.
    assign snap      = snap_d;
    assign scan_done = slot_end && (state_q == StCol3);

endmodule

// File: rtl/keypad_input_port.sv
// Memory-mapped 4x4 keypad input port: debounce, single-press detection and a CPU holding register.
module keypad_input_port
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV       = 4,
    parameter int unsigned DEBOUNCE_SCANS = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    keypad_if.slave    bus,
    output logic [3:0] key_bcd,
    output logic       key_down
);

    localparam logic [3:0] DebMax = 4'(DEBOUNCE_SCANS);

    key_map_t   snap, prev_snap_q, stable_map_q, old_map_q;
    logic       scan_done, map_upd_q, accept, key_event;
    logic [3:0] stable_cnt_q, cnt_d, new_code;
    logic       valid_q, valid_d, ovr_q, ovr_d, key_down_q;
    logic [3:0] code_q, code_d, key_bcd_q, key_bcd_d;

    keypad_col_scanner #(
        .SCAN_DIV(SCAN_DIV)
    ) u_scanner (
        .clock     (clock),
        .reset     (reset),
        .row_in    (row_in),
        .col_out   (col_out),
        .snap      (snap),
        .scan_done (scan_done)
    );

    always_comb begin
        cnt_d  = stable_cnt_q;
        accept = 1'b0;
        if (scan_done) begin
            if (snap == prev_snap_q) begin
                cnt_d = (stable_cnt_q >= DebMax) ? stable_cnt_q : stable_cnt_q + 4'd1;
            end else begin
                cnt_d = 4'd1;
            end
            accept = (cnt_d == DebMax);
        end
    end

    // Only a transition from an idle map to a single key counts as a press.
    assign key_event = map_upd_q && (old_map_q == '0) && is_onehot(stable_map_q);
    assign new_code  = key_code(stable_map_q);

    always_comb begin
        valid_d   = valid_q;
        ovr_d     = ovr_q;
        code_d    = code_q;
        key_bcd_d = key_bcd_q;
        if (key_event) begin
            if (!valid_q) begin
                valid_d   = 1'b1;
                code_d    = new_code;
                key_bcd_d = new_code;
            end else if (bus.rd_strobe) begin
                valid_d   = 1'b1;
                ovr_d     = 1'b0;
                code_d    = new_code;
                key_bcd_d = new_code;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (bus.rd_strobe) begin
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prev_snap_q  <= '0;
            stable_cnt_q <= '0;
            stable_map_q <= '0;
            old_map_q    <= '0;
            map_upd_q    <= 1'b0;
            key_down_q   <= 1'b0;
            valid_q      <= 1'b0;
            ovr_q        <= 1'b0;
            code_q       <= '0;
            key_bcd_q    <= '0;
        end else begin
            if (scan_done) begin
                prev_snap_q  <= snap;
                stable_cnt_q <= cnt_d;
            end
            map_upd_q <= accept;
            if (accept) begin
                old_map_q    <= stable_map_q;
                stable_map_q <= snap;
            end
            key_down_q <= |stable_map_q;
            valid_q    <= valid_d;
            ovr_q      <= ovr_d;
            code_q     <= code_d;
            key_bcd_q  <= key_bcd_d;
        end
    end

    always_comb begin
        bus.key_reg                   = '0;
        bus.key_reg[VALID_BIT]        = valid_q;
        bus.key_reg[OVR_BIT]          = ovr_q;
        bus.key_reg[CODE_LSB +: 4]    = code_q;
    end

    assign key_bcd  = key_bcd_q;
    assign key_down = key_down_q;

endmodule

// File: tb/tb_keypad_input_port.sv
// Randomised bench for keypad_input_port against a scan-level run-length debounce model.
module tb_keypad_input_port;

    localparam int DEB = 3;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] keys  = 16'h0000;
    logic [3:0]  row_in, col_out, key_bcd;
    logic        key_down;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [15:0] m_last, m_stable;
    int          m_run;
    logic        m_valid, m_ovr;
    logic [3:0]  m_code, m_bcd;

    keypad_if bus ();

    keypad_input_port #(
        .SCAN_DIV       (4),
        .DEBOUNCE_SCANS (DEB)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .row_in   (row_in),
        .col_out  (col_out),
        .bus      (bus),
        .key_bcd  (key_bcd),
        .key_down (key_down)
    );

    always #5 clock = ~clock;

    // Physical keypad: a row reads low if any pressed key in it sits on a driven column.
    always_comb begin
        row_in = 4'hF;
        for (int r = 0; r < 4; r++) begin
            row_in[r] = ~|(keys[4*r +: 4] & ~col_out);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    task automatic model_reset();
        m_last = 16'h0; m_stable = 16'h0; m_run = 0;
        m_valid = 1'b0; m_ovr = 1'b0; m_code = 4'h0; m_bcd = 4'h0;
    endtask

    // Called #1 after the edge that ends a scan whose key map was 'map'.
    task automatic finish_scan(input logic [15:0] map, input bit rd);
        logic        ev;
        logic [3:0]  ev_code;
        logic [31:0] exp_reg;
        if (map == m_last) m_run++; else m_run = 1;
        m_last  = map;
        ev      = 1'b0;
        ev_code = 4'h0;
        if (m_run >= DEB) begin
            ev = (m_stable == 16'h0) && ($countones(map) == 1);
            m_stable = map;
        end
        for (int i = 0; i < 16; i++) if (map[i]) ev_code = 4'(i);
        @(negedge clock);
        bus.rd_strobe = rd;
        if (rd) begin
            exp_reg = {m_valid, m_ovr, 26'b0, m_code};
            checks++;
            if (bus.key_reg !== exp_reg) begin
                errors++;
                $display("FAIL prepop_key_reg: got %h expected %h", bus.key_reg, exp_reg);
            end
        end
        @(posedge clock);
        #1;
        bus.rd_strobe = 1'b0;
        if (ev) begin
            if (!m_valid || rd) begin
                m_valid = 1'b1; m_ovr = 1'b0; m_code = ev_code; m_bcd = ev_code;
            end else begin
                m_ovr = 1'b1;
            end
        end else if (rd) begin
            m_valid = 1'b0; m_ovr = 1'b0;
        end
        exp_reg = {m_valid, m_ovr, 26'b0, m_code};
        checks++;
        if (bus.key_reg !== exp_reg) begin
            errors++;
            $display("FAIL key_reg: got %h expected %h (map %h rd %0d)", bus.key_reg, exp_reg, map, rd);
        end
        checks++;
        if (key_bcd !== m_bcd) begin
            errors++;
            $display("FAIL key_bcd: got %h expected %h", key_bcd, m_bcd);
        end
        checks++;
        if (key_down !== (|m_stable)) begin
            errors++;
            $display("FAIL key_down: got %b expected %b", key_down, |m_stable);
        end
        checks++;
        if (col_out !== 4'b1110) begin
            errors++;
            $display("FAIL col_after_scan: got %b expected 1110", col_out);
        end
    endtask

    // Entered #1 after the first edge of a scan; returns at the same phase of the next scan.
    task automatic do_scan(input logic [15:0] map, input bit rd);
        keys = map;
        repeat (15) @(posedge clock);
        #1;
        finish_scan(map, rd);
    endtask

    task automatic test_power_on();
        bus.rd_strobe = 1'b0;
        model_reset();
        repeat (2) @(posedge clock);
        @(negedge clock);
        checks++;
        if ({col_out, bus.key_reg, key_bcd, key_down} !== {4'b1110, 32'h0, 4'h0, 1'b0}) begin
            errors++;
            $display("FAIL reset_values: col %b key_reg %h bcd %h down %b expected 1110/0/0/0",
                     col_out, bus.key_reg, key_bcd, key_down);
        end
        reset = 1'b0;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        logic [3:0] exp_col;
        repeat (8) @(posedge clock);
        #2;
        checks++;
        if (col_out !== 4'b1011) begin
            errors++;
            $display("FAIL col2_before_reset: got %b expected 1011", col_out);
        end
        keys  = 16'h0;
        reset = 1'b1;
        #1;
        checks++;
        if (col_out !== 4'b1110 || bus.key_reg !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid_scan: col %b key_reg %h expected 1110/00000000",
                     col_out, bus.key_reg);
        end
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        for (int n = 1; n <= 16; n++) begin
            @(posedge clock);
            #1;
            exp_col = ~(4'b0001 << ((n / 4) % 4));
            checks++;
            if (col_out !== exp_col) begin
                errors++;
                $display("FAIL col_restart[%0d]: got %b expected %b", n, col_out, exp_col);
            end
        end
        finish_scan(16'h0, 1'b0);
    endtask

    task automatic test_single_key();
        for (int s = 0; s < 4; s++) do_scan(16'h0040, 1'b0);
        checks++;
        if (bus.key_reg !== 32'h8000_0006 || key_bcd !== 4'd6 || key_down !== 1'b1) begin
            errors++;
            $display("FAIL key6: key_reg %h bcd %h down %b expected 80000006/6/1",
                     bus.key_reg, key_bcd, key_down);
        end
    endtask

    task automatic test_glitch();
        do_scan(16'h000F, 1'b0);
        for (int s = 0; s < 4; s++) do_scan(16'h0000, 1'b0);
        checks++;
        if (bus.key_reg !== 32'h0 || key_down !== 1'b0) begin
            errors++;
            $display("FAIL glitch: key_reg %h down %b expected 0/0", bus.key_reg, key_down);
        end
    endtask

    task automatic test_overrun();
        for (int s = 0; s < 3; s++) do_scan(16'h0020, 1'b0);
        for (int s = 0; s < 3; s++) do_scan(16'h0000, 1'b0);
        for (int s = 0; s < 3; s++) do_scan(16'h0200, 1'b0);
        checks++;
        if (bus.key_reg !== 32'hC000_0005) begin
            errors++;
            $display("FAIL overrun: key_reg %h expected c0000005", bus.key_reg);
        end
        do_scan(16'h0000, 1'b1);
        checks++;
        if (bus.key_reg !== 32'h0000_0005) begin
            errors++;
            $display("FAIL read_clears: key_reg %h expected 00000005", bus.key_reg);
        end
        for (int s = 0; s < 2; s++) do_scan(16'h0000, 1'b0);
    endtask

    task automatic test_multi_key();
        for (int s = 0; s < 3; s++) do_scan(16'h8001, 1'b0);
        checks++;
        if (key_down !== 1'b1 || bus.key_reg[31] !== 1'b0) begin
            errors++;
            $display("FAIL multi_key: down %b valid %b expected 1/0", key_down, bus.key_reg[31]);
        end
        for (int s = 0; s < 3; s++) do_scan(16'h0000, 1'b0);
    endtask

    task automatic test_read_with_event();
        for (int s = 0; s < 3; s++) do_scan(16'h0002, 1'b0);
        for (int s = 0; s < 3; s++) do_scan(16'h0000, 1'b0);
        for (int s = 0; s < 3; s++) do_scan(16'h0004, 1'b0);
        for (int s = 0; s < 3; s++) do_scan(16'h0000, 1'b0);
        checks++;
        if (bus.key_reg[31:30] !== 2'b11) begin
            errors++;
            $display("FAIL setup_valid_ovr: flags %b expected 11", bus.key_reg[31:30]);
        end
        do_scan(16'h0008, 1'b0);
        do_scan(16'h0008, 1'b0);
        do_scan(16'h0008, 1'b1);
        checks++;
        if (bus.key_reg !== 32'h8000_0003) begin
            errors++;
            $display("FAIL read_with_event: key_reg %h expected 80000003", bus.key_reg);
        end
        for (int s = 0; s < 3; s++) do_scan(16'h0000, 1'b0);
    endtask

    task automatic test_random();
        logic [15:0] one, map;
        int          hold;
        one = 16'h0001;
        for (int i = 0; i < 25; i++) begin
            case ($urandom_range(0, 3))
                0:       map = 16'h0000;
                3:       map = (one << $urandom_range(0, 15)) | (one << $urandom_range(0, 15));
                default: map = one << $urandom_range(0, 15);
            endcase
            hold = $urandom_range(1, 4);
            for (int j = 0; j < hold; j++) do_scan(map, ($urandom_range(0, 3) == 0));
        end
    endtask

    initial begin
        test_power_on();
        test_reset();
        test_single_key();
        test_reset();
        test_glitch();
        test_overrun();
        test_multi_key();
        test_read_with_event();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
